// File: rtl/interrupt_controller_if.sv
// CPU-side register bus of the interrupt controller (IF at 0xFF0F, IE at 0xFFFF).
// The CPU drives the master modport; the controller uses the slave modport.
interface interrupt_controller_if;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;

    modport master (output a, din, rd, wr, input dout);
    modport slave  (input a, din, rd, wr, output dout);
endinterface

// File: rtl/interrupt_controller.sv
// GameBoy interrupt controller: IF/IE registers, fixed-priority arbitration and req/ack dispatch.
// Optional macro INTC_HALT_WAKE_EN drives wake from pending interrupts for HALT exit.
module interrupt_controller #(
    parameter int         NUM_IRQ       = 5,
    parameter logic [7:0] VECTOR_BASE   = 8'h40,
    parameter int         VECTOR_STRIDE = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    interrupt_controller_if.slave  bus,
    input  logic [NUM_IRQ-1:0]     int_req,
    output logic [NUM_IRQ-1:0]     int_ack,
    output logic                   cpu_int_req,
    input  logic                   cpu_int_ack,
    output logic [7:0]             cpu_int_vector,
    output logic                   wake
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        HOLD
    } state_t;

    state_t             state_q;
    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_d;
    logic [NUM_IRQ-1:0] req_prev_q;
    logic [NUM_IRQ-1:0] int_ack_q;
    logic [7:0]         ie_q;
    logic [7:0]         vector_q;
    logic [IDX_W-1:0]   idx_q;

    logic [NUM_IRQ-1:0] req_rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] win_onehot;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [IDX_W-1:0]   win_idx;
    logic               any_pending;
    logic               wr_if;
    logic               wr_ie;
    logic               unused_rd;

    assign req_rise    = int_req & ~req_prev_q;
    assign pending     = if_q & ie_q[NUM_IRQ-1:0];
    assign any_pending = |pending;
    assign wr_if       = bus.wr && (bus.a == ADDR_IF);
    assign wr_ie       = bus.wr && (bus.a == ADDR_IE);
    // Reads decode on the address alone, so the read strobe carries no information here.
    assign unused_rd   = bus.rd;

    // Scan downwards so the lowest-index pending source is the last to be assigned.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign win_onehot[gi] = any_pending && (win_idx == IDX_W'(gi));
            assign clr_mask[gi]   = (state_q == DISPATCH) && (idx_q == IDX_W'(gi));
            // Gated by rst so a reset landing in DISPATCH suppresses the pulse.
            assign int_ack[gi]    = int_ack_q[gi] & ~rst;
        end
    endgenerate

    // Priority on an IF bit: peripheral edge, then software write, then dispatch clear.
    always_comb begin
        if_d = if_q & ~clr_mask;
        if (wr_if) begin
            if_d = bus.din[NUM_IRQ-1:0];
        end
        if_d = if_d | req_rise;
    end

    always_comb begin
        bus.dout = 8'hFF;
        if (bus.a == ADDR_IF) begin
            bus.dout[NUM_IRQ-1:0] = if_q;
        end else if (bus.a == ADDR_IE) begin
            bus.dout = ie_q;
        end
    end

    assign cpu_int_req    = (state_q == IDLE) && any_pending;
    assign cpu_int_vector = vector_q;

`ifdef INTC_HALT_WAKE_EN
    assign wake = any_pending;
`else
    assign wake = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_q       <= '0;
            ie_q       <= 8'h00;
            req_prev_q <= '0;
            int_ack_q  <= '0;
            idx_q      <= '0;
            vector_q   <= 8'h00;
        end else begin
            if_q       <= if_d;
            req_prev_q <= int_req;
            int_ack_q  <= '0;
            if (wr_ie) begin
                ie_q <= bus.din;
            end
            case (state_q)
                IDLE: begin
                    if (cpu_int_ack && any_pending) begin
                        idx_q     <= win_idx;
                        vector_q  <= VECTOR_BASE + 8'(VECTOR_STRIDE * int'(win_idx));
                        int_ack_q <= win_onehot;
                        state_q   <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // One acknowledge level yields one grant; wait for it to drop.
                    if (!cpu_int_ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller: register access, arbitration, handshake and reset abort.
`timescale 1ns/1ps
module tb_interrupt_controller;

    logic       clk;
    logic       rst;
    logic [4:0] int_req;
    logic [4:0] int_ack;
    logic       cpu_int_req;
    logic       cpu_int_ack;
    logic [7:0] cpu_int_vector;
    logic       wake;

    int tests;
    int fails;
    int ack_pulses;

    interrupt_controller_if bus ();

    interrupt_controller dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .int_req        (int_req),
        .int_ack        (int_ack),
        .cpu_int_req    (cpu_int_req),
        .cpu_int_ack    (cpu_int_ack),
        .cpu_int_vector (cpu_int_vector),
        .wake           (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_rd(input logic [15:0] addr, output logic [7:0] val);
        bus.a  = addr;
        bus.rd = 1'b1;
        #1;
        val    = bus.dout;
        bus.rd = 1'b0;
    endtask

    task automatic reg_wr(input logic [15:0] addr, input logic [7:0] data);
        bus.a   = addr;
        bus.din = data;
        bus.wr  = 1'b1;
        step();
        bus.wr  = 1'b0;
    endtask

    // Count acknowledge pulses and verify they are always one-hot.
    always @(negedge clk) begin
        if (int_ack != 5'b0) begin
            ack_pulses++;
            check("ack_onehot", 32'($onehot(int_ack)), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        tests       = 0;
        fails       = 0;
        ack_pulses  = 0;
        rst         = 1'b1;
        int_req     = 5'b0;
        cpu_int_ack = 1'b0;
        bus.a       = 16'h0000;
        bus.din     = 8'h00;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        reg_rd(16'hFF0F, v); check("rst_if", 32'(v), 32'hE0);
        reg_rd(16'hFFFF, v); check("rst_ie", 32'(v), 32'h00);
        reg_rd(16'h1234, v); check("rd_other", 32'(v), 32'hFF);
        check("rst_cpu_req", 32'(cpu_int_req), 32'd0);
        check("rst_ack", 32'(int_ack), 32'd0);

        // Single timer-style source through the full handshake
        reg_wr(16'hFFFF, 8'h04);
        int_req[2] = 1'b1;
        step();
        reg_rd(16'hFF0F, v); check("t2_if_set", 32'(v), 32'hE4);
        check("t2_cpu_req", 32'(cpu_int_req), 32'd1);
        cpu_int_ack = 1'b1;
        step();
        check("t2_ack", 32'(int_ack), 32'h04);
        check("t2_vec", 32'(cpu_int_vector), 32'h50);
        check("t2_req_masked", 32'(cpu_int_req), 32'd0);
        cpu_int_ack = 1'b0;
        step();
        check("t2_ack_done", 32'(int_ack), 32'd0);
        reg_rd(16'hFF0F, v); check("t2_if_clr", 32'(v), 32'hE0);
        int_req[2] = 1'b0;
        step();
        step();
        reg_rd(16'hFF0F, v); check("t2_no_reset", 32'(v), 32'hE0);
        check("t2_cpu_req_idle", 32'(cpu_int_req), 32'd0);
        check("t2_pulses", 32'(ack_pulses), 32'd1);

        // Simultaneous requests resolve by priority
        reg_wr(16'hFFFF, 8'h1F);
        int_req = 5'b10010;
        step();
        reg_rd(16'hFF0F, v); check("t3_if", 32'(v), 32'hF2);
        cpu_int_ack = 1'b1;
        step();
        check("t3_ack1", 32'(int_ack), 32'h02);
        check("t3_vec1", 32'(cpu_int_vector), 32'h48);
        cpu_int_ack = 1'b0;
        step();
        step();
        check("t3_cpu_req2", 32'(cpu_int_req), 32'd1);
        cpu_int_ack = 1'b1;
        step();
        check("t3_ack2", 32'(int_ack), 32'h10);
        check("t3_vec2", 32'(cpu_int_vector), 32'h60);
        cpu_int_ack = 1'b0;
        int_req     = 5'b0;
        step();
        step();
        check("t3_pulses", 32'(ack_pulses), 32'd3);

        // Held acknowledge grants only once
        int_req = 5'b01001;
        step();
        reg_rd(16'hFF0F, v); check("t4_if", 32'(v), 32'hE9);
        cpu_int_ack = 1'b1;
        repeat (5) step();
        check("t4_one_grant", 32'(ack_pulses), 32'd4);
        check("t4_vec1", 32'(cpu_int_vector), 32'h40);
        check("t4_hold_req", 32'(cpu_int_req), 32'd0);
        cpu_int_ack = 1'b0;
        step();
        check("t4_cpu_req2", 32'(cpu_int_req), 32'd1);
        reg_rd(16'hFF0F, v); check("t4_if_left", 32'(v), 32'hE8);
        cpu_int_ack = 1'b1;
        step();
        check("t4_ack2", 32'(int_ack), 32'h08);
        check("t4_vec2", 32'(cpu_int_vector), 32'h58);
        cpu_int_ack = 1'b0;
        step();
        step();
        check("t4_pulses", 32'(ack_pulses), 32'd5);
        int_req = 5'b0;
        step();

        // Masked request, then set-wins against a software write
        reg_wr(16'hFFFF, 8'h00);
        int_req[0] = 1'b1;
        step();
        reg_rd(16'hFF0F, v); check("t5_if_masked", 32'(v), 32'hE1);
        check("t5_cpu_req", 32'(cpu_int_req), 32'd0);
        check("t5_wake_masked", 32'(wake), 32'd0);
        int_req[3] = 1'b1;
        reg_wr(16'hFF0F, 8'h00);
        reg_rd(16'hFF0F, v); check("t5_set_wins", 32'(v), 32'hE8);
        reg_wr(16'hFFFF, 8'h08);
        check("t5_cpu_req_en", 32'(cpu_int_req), 32'd1);
`ifdef INTC_HALT_WAKE_EN
        check("t5_wake", 32'(wake), 32'd1);
`else
        check("t5_wake", 32'(wake), 32'd0);
`endif

        // Reset during DISPATCH aborts the grant
        cpu_int_ack = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check("t6_ack_gated", 32'(int_ack), 32'd0);
        step();
        rst         = 1'b0;
        cpu_int_ack = 1'b0;
        reg_rd(16'hFF0F, v); check("t6_if", 32'(v), 32'hE0);
        reg_rd(16'hFFFF, v); check("t6_ie", 32'(v), 32'h00);
        check("t6_vec", 32'(cpu_int_vector), 32'h00);
        check("t6_cpu_req", 32'(cpu_int_req), 32'd0);
        step();
        check("t6_pulses", 32'(ack_pulses), 32'd5);
        int_req = 5'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
